// File: rtl/dtree_pkg.sv
// Shared codes, targets and node states for the dynamic expression tree.
package dtree_pkg;

    localparam logic [31:0] K_LEAF = 32'd8;

    typedef enum logic [2:0] {
        M_EMPTY = 3'd0,
        M_EOF   = 3'd1,
        M_READY = 3'd2,
        M_WRITE = 3'd3,
        M_READ  = 3'd4
    } VMeta;

    typedef enum logic [2:0] {
        K_STOP  = 3'd5,
        K_ERR   = 3'd6,
        K_APPLY = 3'd7
    } VKind;

    typedef enum logic [1:0] {
        TGT_PARENT   = 2'd0,
        TGT_CHILDREN = 2'd1,
        TGT_LEFT     = 2'd2,
        TGT_RIGHT    = 2'd3
    } VTarget;

    localparam logic [1:0] COM_WORK  = 2'd0;
    localparam logic [1:0] COM_CLEAR = 2'd1;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WR_L     = 4'd1;
    localparam logic [3:0] S_WR_R     = 4'd2;
    localparam logic [3:0] S_READY    = 4'd3;
    localparam logic [3:0] S_LEAF_EOF = 4'd4;
    localparam logic [3:0] S_RD_LW    = 4'd5;
    localparam logic [3:0] S_RD_L     = 4'd6;
    localparam logic [3:0] S_RD_RW    = 4'd7;
    localparam logic [3:0] S_RD_R     = 4'd8;
    localparam logic [3:0] S_ERR      = 4'd9;

    function automatic logic is_leaf_tok(input logic [31:0] tok);
        return tok >= K_LEAF;
    endfunction

endpackage

// File: rtl/dtree_in_filter.sv
// Addressing filter: messages not aimed at this node read as EMPTY.
module dtree_in_filter
    import dtree_pkg::*;
#(
    parameter int DW      = 8,
    parameter int IMRIGHT = 0
) (
    input  logic [DW-1:0] pMsg,
    input  logic [1:0]    pTgt,
    input  logic [DW-1:0] lMsg,
    input  logic [1:0]    lTgt,
    input  logic [DW-1:0] rMsg,
    input  logic [1:0]    rTgt,
    output logic [DW-1:0] pSeen,
    output logic [DW-1:0] lSeen,
    output logic [DW-1:0] rSeen
);

    localparam logic [1:0] MY_TGT = (IMRIGHT != 0) ? TGT_RIGHT : TGT_LEFT;

    // Pass each message only when its target addresses this node.
    always_comb begin
        pSeen = {DW{1'b0}};
        lSeen = {DW{1'b0}};
        rSeen = {DW{1'b0}};
        if (pTgt == TGT_CHILDREN || pTgt == MY_TGT) begin
            pSeen = pMsg;
        end else begin
            pSeen = {DW{1'b0}};
        end
        if (lTgt == TGT_PARENT) begin
            lSeen = lMsg;
        end else begin
            lSeen = {DW{1'b0}};
        end
        if (rTgt == TGT_PARENT) begin
            rSeen = rMsg;
        end else begin
            rSeen = {DW{1'b0}};
        end
    end

endmodule

// File: rtl/dyna_tree_p.sv
// Recursive subtree of dtree_node cells; the bottom row sees STOP from its
// missing children and error flags are ORed toward the root.
module dyna_tree_p
    import dtree_pkg::*;
#(
    parameter int DW      = 8,
    parameter int LEVEL   = 4,
    parameter int IMRIGHT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    glob_com,
    input  logic [DW-1:0] p_msg,
    input  logic [1:0]    p_tgt,
    output logic [DW-1:0] out_msg,
    output logic [1:0]    out_tgt,
    output logic          err
);

    logic [DW-1:0] lMsg_s, rMsg_s;
    logic [1:0]    lTgt_s, rTgt_s;
    logic          nodeErr_s, lErr_s, rErr_s;

    dtree_node #(.DW(DW), .LEVEL(LEVEL), .IMRIGHT(IMRIGHT)) u_node (
        .clk(clk), .rst(rst), .glob_com(glob_com),
        .p_msg(p_msg), .p_tgt(p_tgt),
        .l_msg(lMsg_s), .l_tgt(lTgt_s),
        .r_msg(rMsg_s), .r_tgt(rTgt_s),
        .out_msg(out_msg), .out_tgt(out_tgt), .err(nodeErr_s)
    );

    generate
        if (LEVEL > 0) begin : g_kids
            dyna_tree_p #(.DW(DW), .LEVEL(LEVEL - 1), .IMRIGHT(0)) u_left (
                .clk(clk), .rst(rst), .glob_com(glob_com),
                .p_msg(out_msg), .p_tgt(out_tgt),
                .out_msg(lMsg_s), .out_tgt(lTgt_s), .err(lErr_s)
            );
            dyna_tree_p #(.DW(DW), .LEVEL(LEVEL - 1), .IMRIGHT(1)) u_right (
                .clk(clk), .rst(rst), .glob_com(glob_com),
                .p_msg(out_msg), .p_tgt(out_tgt),
                .out_msg(rMsg_s), .out_tgt(rTgt_s), .err(rErr_s)
            );
        end else begin : g_bottom
            assign lMsg_s = {{(DW-3){1'b0}}, K_STOP};
            assign rMsg_s = {{(DW-3){1'b0}}, K_STOP};
            assign lTgt_s = TGT_PARENT;
            assign rTgt_s = TGT_PARENT;
            assign lErr_s = 1'b0;
            assign rErr_s = 1'b0;
        end
    endgenerate

    assign err = nodeErr_s | lErr_s | rErr_s;

endmodule

// File: rtl/dtree_node.sv
// One cell of the expression tree: stores a token, routes prefix writes to its
// children and replays the subtree in the same order on READ.
module dtree_node
    import dtree_pkg::*;
#(
    parameter int DW      = 8,
    parameter int LEVEL   = 4,
    parameter int IMRIGHT = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    glob_com,
    input  logic [DW-1:0] p_msg,
    input  logic [1:0]    p_tgt,
    input  logic [DW-1:0] l_msg,
    input  logic [1:0]    l_tgt,
    input  logic [DW-1:0] r_msg,
    input  logic [1:0]    r_tgt,
    output logic [DW-1:0] out_msg,
    output logic [1:0]    out_tgt,
    output logic          err
);

    localparam logic [DW-1:0] T_EMPTY = {{(DW-3){1'b0}}, M_EMPTY};
    localparam logic [DW-1:0] T_EOF   = {{(DW-3){1'b0}}, M_EOF};
    localparam logic [DW-1:0] T_READY = {{(DW-3){1'b0}}, M_READY};
    localparam logic [DW-1:0] T_READ  = {{(DW-3){1'b0}}, M_READ};
    localparam logic [DW-1:0] T_STOP  = {{(DW-3){1'b0}}, K_STOP};
    localparam logic [DW-1:0] T_ERR   = {{(DW-3){1'b0}}, K_ERR};
    localparam logic [DW-1:0] T_APPLY = {{(DW-3){1'b0}}, K_APPLY};

    logic [DW-1:0] p_s, l_s, r_s;
    logic [3:0]    state_r, nextState_s;
    logic [DW-1:0] value_r, nextValue_s, nextMsg_s;
    logic [1:0]    nextTgt_s;
    logic          nextErr_s;
    logic          inWrRd_s;

    dtree_in_filter #(.DW(DW), .IMRIGHT(IMRIGHT)) u_filter (
        .pMsg (p_msg), .pTgt (p_tgt),
        .lMsg (l_msg), .lTgt (l_tgt),
        .rMsg (r_msg), .rTgt (r_tgt),
        .pSeen(p_s),   .lSeen(l_s),   .rSeen(r_s)
    );

    assign inWrRd_s = (state_r == S_WR_L) || (state_r == S_WR_R) || (state_r == S_RD_LW) ||
                      (state_r == S_RD_L) || (state_r == S_RD_RW) || (state_r == S_RD_R);

    // Next-state, next-output and error decisions for work mode.
    always_comb begin
        nextState_s = state_r;
        nextValue_s = value_r;
        nextMsg_s   = T_EMPTY;
        nextTgt_s   = TGT_PARENT;
        nextErr_s   = err;
        if ((state_r != S_IDLE && (l_s == T_ERR || r_s == T_ERR)) ||
            (inWrRd_s && (l_s == T_STOP || r_s == T_STOP))) begin
            nextMsg_s   = T_ERR;
            nextErr_s   = 1'b1;
            nextState_s = S_ERR;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (p_s == T_APPLY) begin
                        if (LEVEL > 0) begin
                            nextValue_s = T_APPLY;
                            nextState_s = S_WR_L;
                        end else begin
                            nextMsg_s   = T_ERR;
                            nextErr_s   = 1'b1;
                            nextState_s = S_ERR;
                        end
                    end else if (is_leaf_tok(32'(p_s))) begin
                        nextValue_s = p_s;
                        nextMsg_s   = T_READY;
                        nextState_s = S_READY;
                    end else begin
                        nextState_s = S_IDLE;
                    end
                end
                S_WR_L: begin
                    if (l_s == T_READY) begin
                        nextMsg_s   = p_s;
                        nextTgt_s   = TGT_RIGHT;
                        nextState_s = S_WR_R;
                    end else if (l_s == T_EMPTY) begin
                        nextMsg_s = p_s;
                        nextTgt_s = TGT_LEFT;
                    end else begin
                        nextMsg_s = T_EMPTY;
                    end
                end
                S_WR_R: begin
                    if (r_s == T_READY) begin
                        nextMsg_s   = T_READY;
                        nextState_s = S_READY;
                    end else if (r_s == T_EMPTY) begin
                        nextMsg_s = p_s;
                        nextTgt_s = TGT_RIGHT;
                    end else begin
                        nextMsg_s = T_EMPTY;
                    end
                end
                S_READY: begin
                    if (p_s == T_READ) begin
                        nextMsg_s   = value_r;
                        nextState_s = (value_r == T_APPLY) ? S_RD_LW : S_LEAF_EOF;
                    end else begin
                        nextMsg_s = T_READY;
                    end
                end
                S_LEAF_EOF: begin
                    nextMsg_s   = T_EOF;
                    nextState_s = S_READY;
                end
                S_RD_LW, S_RD_RW: begin
                    if ((state_r == S_RD_LW ? l_s : r_s) == T_READY) begin
                        nextMsg_s   = T_READ;
                        nextTgt_s   = (state_r == S_RD_LW) ? TGT_LEFT : TGT_RIGHT;
                        nextState_s = (state_r == S_RD_LW) ? S_RD_L : S_RD_R;
                    end else begin
                        nextMsg_s = T_EMPTY;
                    end
                end
                // A child still showing READY has not yet seen the READ; treat it as a gap.
                S_RD_L: begin
                    if (l_s == T_EOF) begin
                        nextState_s = S_RD_RW;
                    end else if (l_s != T_EMPTY && l_s != T_READY) begin
                        nextMsg_s = l_s;
                    end else begin
                        nextMsg_s = T_EMPTY;
                    end
                end
                S_RD_R: begin
                    if (r_s == T_EOF) begin
                        nextMsg_s   = T_EOF;
                        nextState_s = S_READY;
                    end else if (r_s != T_EMPTY && r_s != T_READY) begin
                        nextMsg_s = r_s;
                    end else begin
                        nextMsg_s = T_EMPTY;
                    end
                end
                S_ERR: begin
                    nextMsg_s = T_ERR;
                end
                default: begin
                    nextState_s = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers: reset/clear, freeze hold, or advance.
    always_ff @(posedge clk) begin
        if (rst || glob_com == COM_CLEAR) begin
            state_r <= S_IDLE;
            value_r <= {DW{1'b0}};
            out_msg <= {DW{1'b0}};
            out_tgt <= TGT_PARENT;
            err     <= 1'b0;
        end else if (glob_com[1]) begin
            state_r <= state_r;
            value_r <= value_r;
            out_msg <= out_msg;
            out_tgt <= out_tgt;
            err     <= err;
        end else begin
            state_r <= nextState_s;
            value_r <= nextValue_s;
            out_msg <= nextMsg_s;
            out_tgt <= nextTgt_s;
            err     <= nextErr_s;
        end
    end

endmodule
